// File: rtl/md5_stream_ctrl.sv
// MD5 front-end: packs a byte stream into padded 512-bit blocks for md5_core.
// Optional cycle_cnt port enabled by MD5_STREAM_CTRL_CYCLE_CNT_EN.
module md5_stream_ctrl #(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic [511:0] core_block,
    output logic         core_start,
    output logic         core_resume,
    input  logic         core_done,
    input  logic [127:0] core_hash,
    output logic         hash_valid,
    input  logic         hash_ready,
    output logic [127:0] hash_out
`ifdef MD5_STREAM_CTRL_CYCLE_CNT_EN
    ,
    output logic [31:0]  cycle_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, FILL, PAD, ISSUE, BUSY, OUT} state_t;
    typedef enum logic [1:0] {P_DATA, P_ZLEN, P_FULL, P_FINAL} pend_t;

    state_t           state;
    pend_t            pend;
    logic [6:0]       ptr;
    logic [LEN_W-1:0] cnt;
    logic             first_blk;
    logic             busy_first;
    logic             xfer;
    logic [2:0]       nb;
    logic [63:0]      bit_len;

    assign xfer    = in_valid & in_ready;
    assign nb      = (in_last && in_nbytes <= 3'd4) ? in_nbytes : 3'd4;
    assign bit_len = 64'(cnt) << 3;

    function automatic logic [511:0] put_word(input logic [511:0] b,
                                              input logic [6:0]   p,
                                              input logic [31:0]  d,
                                              input logic [2:0]   n);
        logic [511:0] r;
        r = b;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(n) && int'(p) + k < 64)
                r[511 - 8*(int'(p) + k) -: 8] = d[31 - 8*k -: 8];
        end
        return r;
    endfunction

    function automatic logic [511:0] put_byte(input logic [511:0] b,
                                              input logic [6:0]   p,
                                              input logic [7:0]   v);
        logic [511:0] r;
        r = b;
        if (int'(p) < 64)
            r[511 - 8*int'(p) -: 8] = v;
        return r;
    endfunction

    // Length field occupies bytes 56..63, least significant byte first.
    function automatic logic [511:0] put_len(input logic [511:0] b,
                                             input logic [63:0]  len);
        logic [511:0] r;
        r = b;
        for (int i = 0; i < 8; i++)
            r[511 - 8*(56 + i) -: 8] = len[8*i +: 8];
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pend        <= P_DATA;
            ptr         <= '0;
            cnt         <= '0;
            first_blk   <= 1'b1;
            busy_first  <= 1'b0;
            in_ready    <= 1'b0;
            core_start  <= 1'b0;
            core_resume <= 1'b0;
            hash_valid  <= 1'b0;
            hash_out    <= '0;
            core_block  <= '0;
        end else begin
            core_start  <= 1'b0;
            core_resume <= 1'b0;
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        core_block <= put_word('0, 7'd0, in_data, nb);
                        ptr        <= 7'(nb);
                        cnt        <= cnt + LEN_W'(nb);
                        if (in_last) begin
                            in_ready <= 1'b0;
                            state    <= PAD;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (xfer) begin
                        core_block <= put_word(core_block, ptr, in_data, nb);
                        ptr        <= ptr + 7'(nb);
                        cnt        <= cnt + LEN_W'(nb);
                        if (in_last) begin
                            in_ready <= 1'b0;
                            state    <= PAD;
                        end else if (ptr + 7'(nb) == 7'd64) begin
                            in_ready    <= 1'b0;
                            pend        <= P_DATA;
                            state       <= ISSUE;
                            core_start  <= first_blk;
                            core_resume <= ~first_blk;
                        end
                    end
                end
                PAD: begin
                    if (ptr <= 7'd55) begin
                        core_block <= put_len(put_byte(core_block, ptr, 8'h80),
                                              bit_len);
                        pend       <= P_FINAL;
                    end else if (ptr != 7'd64) begin
                        core_block <= put_byte(core_block, ptr, 8'h80);
                        pend       <= P_ZLEN;
                    end else begin
                        pend <= P_FULL;
                    end
                    state       <= ISSUE;
                    core_start  <= first_blk;
                    core_resume <= ~first_blk;
                end
                ISSUE: begin
                    first_blk  <= 1'b0;
                    busy_first <= 1'b1;
                    state      <= BUSY;
                end
                BUSY: begin
                    // done is stale on the first cycle after start/resume
                    if (busy_first) begin
                        busy_first <= 1'b0;
                    end else if (core_done) begin
                        unique case (pend)
                            P_DATA: begin
                                core_block <= '0;
                                ptr        <= '0;
                                in_ready   <= 1'b1;
                                state      <= FILL;
                            end
                            P_ZLEN: begin
                                core_block  <= put_len('0, bit_len);
                                pend        <= P_FINAL;
                                state       <= ISSUE;
                                core_resume <= 1'b1;
                            end
                            P_FULL: begin
                                core_block  <= put_len(put_byte('0, 7'd0, 8'h80),
                                                       bit_len);
                                pend        <= P_FINAL;
                                state       <= ISSUE;
                                core_resume <= 1'b1;
                            end
                            default: begin
                                hash_out   <= core_hash;
                                hash_valid <= 1'b1;
                                state      <= OUT;
                            end
                        endcase
                    end
                end
                OUT: begin
                    if (hash_ready) begin
                        hash_valid <= 1'b0;
                        cnt        <= '0;
                        first_blk  <= 1'b1;
                        in_ready   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MD5_STREAM_CTRL_CYCLE_CNT_EN
    logic cyc_run;
    logic to_out;

    assign to_out = (state == BUSY) && !busy_first && core_done
                    && (pend == P_FINAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            cyc_run   <= 1'b0;
        end else if (state == IDLE && xfer) begin
            cycle_cnt <= '0;
            cyc_run   <= 1'b1;
        end else if (cyc_run) begin
            if (cycle_cnt != 32'hFFFF_FFFF)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (to_out)
                cyc_run <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/md5_stream_ctrl.md
Name: md5_stream_ctrl

Overview:
- Front-end sequencer for md5_core.
- Accepts a byte-granular message as a stream of 32-bit words on a valid/ready handshake and assembles 512-bit blocks.
- Applies MD5 padding and the 64-bit length field, drives core start/resume per block, holds each block stable while the core runs, and returns the 128-bit digest on a valid/ready output.

Parameters:
- LEN_W, 32, width of internal message byte counter; bit length = count*8, zero-extended into the 64-bit length field.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  controller can accept a word this cycle
- in_data  in  32  message bytes; in_data[31:24] is earliest byte
- in_last  in  1  final word of message
- in_nbytes  in  3  valid bytes in word (0..4), MSB-first; must be 4 unless in_last; 0 legal only with in_last
- core_block  out  512  to md5_core input_data; byte k of block at bits [511-8k -: 8]
- core_start  out  1  one-cycle pulse, first block of a message
- core_resume  out  1  one-cycle pulse, subsequent blocks
- core_done  in  1  md5_core done level
- core_hash  in  128  md5_core hash, already in digest byte order
- hash_valid  out  1  digest available
- hash_ready  in  1  digest consumer accepts
- hash_out  out  128  registered digest

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0 during reset, 1 in IDLE after release; core_start=core_resume=0; hash_valid=0; hash_out=0; core_block=0; byte count=0; first_blk=1. Reset mid-message aborts silently; the core is not reset by this block.
- States: IDLE, FILL, PAD, ISSUE, BUSY, OUT.
- Word transfer = in_valid & in_ready. in_ready=1 only in IDLE and FILL.
- IDLE: a transfer writes the word at byte 0 and enters FILL.
- FILL: each transfer writes in_nbytes bytes at the current block byte pointer p and adds in_nbytes to the count.
  - Non-last word and p reaches 64 -> ISSUE (pending = data).
  - Last word -> PAD.
- PAD (one cycle) builds the tail, where p = bytes used in the current block:
  - p<=55: byte p=0x80, zeros to byte 55, bytes 56..63 = bit length little-endian (byte 56 = LSB). Final block.
  - 56<=p<=63: byte p=0x80, zeros to 63. Non-final; the next block is zeros + length.
  - p==64: issue the block as is. Next block is 0x80 at byte 0, zeros, length.
- ISSUE: pulse core_start if first_blk else core_resume (exactly one cycle), clear first_blk, go to BUSY.
- BUSY: core_block held constant. Wait for core_done=1, ignoring core_done in the first BUSY cycle (the core lowers done the cycle after it samples start/resume).
  - On done with more data pending -> FILL, p=0.
  - On done with a pad block pending -> build it, go to ISSUE.
  - On done after the final block -> latch core_hash into hash_out, go to OUT.
- OUT: hash_valid=1 until hash_ready sampled high. Then return to IDLE, clear count, set first_blk=1. hash_out is held until the next digest.
- core_start and core_resume are never both high and never asserted outside ISSUE.
- Block bytes beyond the written and padded region are always zero-filled; no stale data from a prior message.
- Count wraps modulo 2^LEN_W; messages longer than 2^LEN_W-1 bytes are unsupported.
- Illegal in_nbytes (>4, or <4 without in_last) is treated as 4.

Optional Feature:
- MD5_STREAM_CTRL_CYCLE_CNT_EN adds an output port cycle_cnt [31:0].
  - Cleared on the first word transfer of a message; increments every cycle until the transition into OUT, then holds; saturates at 0xFFFFFFFF. Reset value 0.
- Without the macro: no port and no counter logic; behaviour is otherwise identical.

Test Plan:
- Empty message: one transfer, in_last=1, in_nbytes=0 -> single core_start; block = 0x80 then zeros; hash_out=d41d8cd98f00b204e9800998ecf8427e.
- "abc": in_data=0x61626300, in_nbytes=3, last -> one start, zero resumes, length byte 56=0x18; hash_out=900150983cd24fb0d6963f7d28e17f72.
- 56-byte message (14 full words): two blocks (start then resume). Block 1 byte 56=0x80; block 2 bytes 56..57=0xC0,0x01. Digest matches a software reference.
- 64-byte message: p==64 path. Second block byte0=0x80, byte 56..57=0x00,0x02. Exactly one resume; check core_block stable throughout both BUSY periods.
- Back-to-back "abc" messages with hash_ready held low 10 cycles: hash_valid held, in_ready=0 during OUT. Second message uses core_start (not resume); identical digest.
- rst_n pulsed low in mid-BUSY: all outputs at reset values immediately. A subsequent "abc" yields the correct digest after the core returns done.
